// File: rtl/audio_capture_channel.sv
// audio_capture_channel
// Captures a stereo 16-bit sample stream on each toggle of the sample clock.
// Samples are packed into 32-bit words and held in a small FIFO. A DMA master
// then writes those words to memory at consecutive addresses.
// Build option: define AUDIO_CAPTURE_MONO_MIX_EN so that mono capture stores
// (left + right) >>> 1. Without the macro, mono capture stores the left sample only.
//
// DMA states
//   state     | meaning
//   DS_IDLE   | waiting for FIFO data; issues the FIFO read
//   DS_POP    | FIFO read data settling into fifo_rdata
//   DS_LATCH  | address/data registered onto the bus, request raised
//   DS_WRITE  | request held until i_dma_ready
module audio_capture_channel #(
    parameter int FIFO_DEPTH = 4
) (
    input  logic        i_clock,
    input  logic        i_reset,
    input  logic        i_dma_setup_request,
    input  logic        i_dma_setup_append_or_replace,
    input  logic        i_dma_setup_mono_or_stereo,
    input  logic [31:0] i_dma_setup_address,
    input  logic [23:0] i_dma_setup_count,
    output logic        o_dma_request,
    output logic [31:0] o_dma_address,
    output logic [31:0] o_dma_wdata,
    input  logic        i_dma_ready,
    output logic        o_busy,
    output logic [7:0]  o_overrun_count,
    input  logic        i_input_sample_clock,
    input  logic [15:0] i_input_sample_left,
    input  logic [15:0] i_input_sample_right
);

    localparam int AW = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
    localparam int CW = $clog2(FIFO_DEPTH + 1);
    localparam logic [AW-1:0] LAST_PTR   = AW'(FIFO_DEPTH - 1);
    localparam logic [CW-1:0] FULL_COUNT = CW'(FIFO_DEPTH);

    typedef enum logic [1:0] {
        DS_IDLE,
        DS_POP,
        DS_LATCH,
        DS_WRITE
    } dma_state_t;

    dma_state_t  dma_state;
    logic [31:0] dma_address;

    // active command
    logic        last_clk;
    logic [23:0] capture_count;
    logic        cmd_stereo;

    // mono first-half holding register
    logic [15:0] hold;
    logic        hold_valid;

    // pending (append) slot
    logic        pending_valid;
    logic        pending_stereo;
    logic [31:0] pending_address;
    logic [23:0] pending_count;

    // replace waiting for an in-flight write to finish
    logic        repl_valid;
    logic        repl_stereo;
    logic [31:0] repl_address;
    logic [23:0] repl_count;

    // sample FIFO
    logic [31:0]   fifo_mem [FIFO_DEPTH];
    logic [AW-1:0] wr_ptr;
    logic [AW-1:0] rd_ptr;
    logic [CW-1:0] fifo_count;
    logic [31:0]   fifo_rdata;
    logic          fifo_empty;
    logic          fifo_full;
    logic          fifo_pop;

    // capture-side decisions
    logic        tick;
    logic [15:0] mono_sample;
    logic        push;
    logic [31:0] push_data;
    logic        cap_dec;
    logic        ovr_inc;
    logic        hold_load;
    logic        hold_clear;

    // command-side decisions
    logic        is_idle;
    logic        write_busy;
    logic        req_replace;
    logic        req_append;
    logic        load_en;
    logic        load_stereo;
    logic [31:0] load_address;
    logic [23:0] load_count;
    logic        flush;
    logic        clr_overrun;
    logic        slot_set;
    logic        slot_clr;
    logic        repl_set;
    logic        repl_clr;

`ifdef AUDIO_CAPTURE_MONO_MIX_EN
    logic [16:0] mix_sum;
    assign mix_sum     = {i_input_sample_left[15], i_input_sample_left}
                       + {i_input_sample_right[15], i_input_sample_right};
    assign mono_sample = mix_sum[16:1];
`else
    assign mono_sample = i_input_sample_left;
`endif

    assign tick        = i_input_sample_clock ^ last_clk;
    assign fifo_empty  = (fifo_count == '0);
    assign fifo_full   = (fifo_count == FULL_COUNT);
    assign is_idle     = (capture_count == '0) && fifo_empty && !hold_valid
                       && (dma_state == DS_IDLE);
    assign write_busy  = (dma_state == DS_WRITE) && !i_dma_ready;
    assign req_replace = i_dma_setup_request && !i_dma_setup_append_or_replace;
    assign req_append  = i_dma_setup_request && i_dma_setup_append_or_replace;
    assign fifo_pop    = (dma_state == DS_IDLE) && !fifo_empty && !flush;

    assign o_busy = (capture_count != '0) | pending_valid | !fifo_empty
                  | hold_valid | (dma_state != DS_IDLE);

    // Decide what a sample-clock tick does, always against the current command.
    always_comb begin
        push       = 1'b0;
        push_data  = '0;
        cap_dec    = 1'b0;
        ovr_inc    = 1'b0;
        hold_load  = 1'b0;
        hold_clear = 1'b0;
        if (tick && (capture_count != '0)) begin
            if (cmd_stereo) begin
                if (fifo_full) begin
                    ovr_inc = 1'b1;
                end else begin
                    push      = 1'b1;
                    push_data = {i_input_sample_left, i_input_sample_right};
                    cap_dec   = 1'b1;
                end
            end else if (!hold_valid) begin
                if (fifo_full) begin
                    ovr_inc = 1'b1;
                end else begin
                    cap_dec = 1'b1;
                    if (capture_count == 24'd1) begin
                        push      = 1'b1;
                        push_data = {16'h0000, mono_sample};
                    end else begin
                        hold_load = 1'b1;
                    end
                end
            end else begin
                // The FIFO only drains between ticks, so the slot freed by the
                // first half is still free here.
                push       = 1'b1;
                push_data  = {mono_sample, hold};
                cap_dec    = 1'b1;
                hold_clear = 1'b1;
            end
        end
    end

    // Decide command loading, flushing and pending/replace slot updates.
    always_comb begin
        load_en      = 1'b0;
        load_stereo  = 1'b0;
        load_address = '0;
        load_count   = '0;
        flush        = 1'b0;
        clr_overrun  = 1'b0;
        slot_set     = 1'b0;
        slot_clr     = 1'b0;
        repl_set     = 1'b0;
        repl_clr     = 1'b0;
        if (req_replace) begin
            clr_overrun = 1'b1;
            slot_clr    = 1'b1;
            if (!write_busy) begin
                load_en      = 1'b1;
                load_stereo  = i_dma_setup_mono_or_stereo;
                load_address = i_dma_setup_address;
                load_count   = i_dma_setup_count;
                flush        = !is_idle;
                repl_clr     = 1'b1;
            end else begin
                repl_set = 1'b1;
            end
        end else if (repl_valid && !write_busy) begin
            load_en      = 1'b1;
            load_stereo  = repl_stereo;
            load_address = repl_address;
            load_count   = repl_count;
            flush        = 1'b1;
            clr_overrun  = 1'b1;
            repl_clr     = 1'b1;
            slot_set     = req_append;
        end else if (is_idle && pending_valid) begin
            load_en      = 1'b1;
            load_stereo  = pending_stereo;
            load_address = pending_address;
            load_count   = pending_count;
            slot_clr     = 1'b1;
            slot_set     = req_append;
        end else if (req_append) begin
            if (is_idle) begin
                load_en      = 1'b1;
                load_stereo  = i_dma_setup_mono_or_stereo;
                load_address = i_dma_setup_address;
                load_count   = i_dma_setup_count;
            end else begin
                slot_set = 1'b1;
            end
        end
    end

    // Capture state, command registers, overrun counter and command slots.
    always_ff @(posedge i_clock or negedge i_reset) begin
        if (!i_reset) begin
            last_clk        <= 1'b0;
            capture_count   <= '0;
            cmd_stereo      <= 1'b0;
            hold            <= '0;
            hold_valid      <= 1'b0;
            o_overrun_count <= '0;
            pending_valid   <= 1'b0;
            pending_stereo  <= 1'b0;
            pending_address <= '0;
            pending_count   <= '0;
            repl_valid      <= 1'b0;
            repl_stereo     <= 1'b0;
            repl_address    <= '0;
            repl_count      <= '0;
        end else begin
            last_clk <= i_input_sample_clock;

            if (load_en) begin
                capture_count <= load_count;
                cmd_stereo    <= load_stereo;
            end else if (cap_dec) begin
                capture_count <= capture_count - 24'd1;
            end

            if (flush) begin
                hold       <= '0;
                hold_valid <= 1'b0;
            end else if (hold_load) begin
                hold       <= mono_sample;
                hold_valid <= 1'b1;
            end else if (hold_clear) begin
                hold_valid <= 1'b0;
            end

            if (clr_overrun) begin
                o_overrun_count <= '0;
            end else if (ovr_inc && (o_overrun_count != 8'hFF)) begin
                o_overrun_count <= o_overrun_count + 8'd1;
            end

            if (slot_set) begin
                pending_valid   <= 1'b1;
                pending_stereo  <= i_dma_setup_mono_or_stereo;
                pending_address <= i_dma_setup_address;
                pending_count   <= i_dma_setup_count;
            end else if (slot_clr) begin
                pending_valid <= 1'b0;
            end

            if (repl_set) begin
                repl_valid   <= 1'b1;
                repl_stereo  <= i_dma_setup_mono_or_stereo;
                repl_address <= i_dma_setup_address;
                repl_count   <= i_dma_setup_count;
            end else if (repl_clr) begin
                repl_valid <= 1'b0;
            end
        end
    end

    // FIFO storage array; contents are don't-care whenever the count says empty.
    always_ff @(posedge i_clock) begin
        if (push && !flush) begin
            fifo_mem[wr_ptr] <= push_data;
        end
    end

    // FIFO pointers, occupancy and registered read data.
    always_ff @(posedge i_clock or negedge i_reset) begin
        if (!i_reset) begin
            wr_ptr     <= '0;
            rd_ptr     <= '0;
            fifo_count <= '0;
            fifo_rdata <= '0;
        end else if (flush) begin
            wr_ptr     <= '0;
            rd_ptr     <= '0;
            fifo_count <= '0;
        end else begin
            if (push) begin
                wr_ptr <= (wr_ptr == LAST_PTR) ? '0 : wr_ptr + AW'(1);
            end
            if (fifo_pop) begin
                fifo_rdata <= fifo_mem[rd_ptr];
                rd_ptr     <= (rd_ptr == LAST_PTR) ? '0 : rd_ptr + AW'(1);
            end
            case ({push, fifo_pop})
                2'b10:   fifo_count <= fifo_count + CW'(1);
                2'b01:   fifo_count <= fifo_count - CW'(1);
                default: fifo_count <= fifo_count;
            endcase
        end
    end

    // DMA write master: pop, latch, then hold the request until accepted.
    always_ff @(posedge i_clock or negedge i_reset) begin
        if (!i_reset) begin
            dma_state     <= DS_IDLE;
            dma_address   <= '0;
            o_dma_request <= 1'b0;
            o_dma_address <= '0;
            o_dma_wdata   <= '0;
        end else begin
            case (dma_state)
                DS_IDLE: begin
                    if (fifo_pop) begin
                        dma_state <= DS_POP;
                    end
                end
                DS_POP: begin
                    dma_state <= DS_LATCH;
                end
                DS_LATCH: begin
                    o_dma_wdata   <= fifo_rdata;
                    o_dma_address <= dma_address;
                    o_dma_request <= 1'b1;
                    dma_state     <= DS_WRITE;
                end
                DS_WRITE: begin
                    if (i_dma_ready) begin
                        o_dma_request <= 1'b0;
                        dma_address   <= dma_address + 32'd4;
                        dma_state     <= DS_IDLE;
                    end
                end
                default: dma_state <= DS_IDLE;
            endcase

            // A flush only happens outside an unfinished write, so dropping
            // back to idle here abandons at most a popped-but-unsent word.
            if (flush) begin
                dma_state     <= DS_IDLE;
                o_dma_request <= 1'b0;
            end
            if (load_en) begin
                dma_address <= load_address;
            end
        end
    end

endmodule

// File: tb/tb_audio_capture_channel.sv
// Testbench for audio_capture_channel: directed scenarios plus randomized
// commands, compared against a word-level model of the expected bus writes.
module tb_audio_capture_channel;

`ifdef AUDIO_CAPTURE_MONO_MIX_EN
    localparam bit MONO_MIX = 1'b1;
`else
    localparam bit MONO_MIX = 1'b0;
`endif

    logic        clk;
    logic        rst_n;
    logic        req;
    logic        app;
    logic        st;
    logic [31:0] s_addr;
    logic [23:0] s_cnt;
    logic        o_dma_request;
    logic [31:0] o_dma_address;
    logic [31:0] o_dma_wdata;
    logic        i_dma_ready;
    logic        o_busy;
    logic [7:0]  o_overrun_count;
    logic        s_clk;
    logic [15:0] s_left;
    logic [15:0] s_right;

    int errors = 0;
    int checks = 0;

    logic [63:0] exp_q[$];
    logic [63:0] got_q[$];
    int          ready_delay = 0;
    bit          ready_hold  = 1'b0;

    audio_capture_channel #(.FIFO_DEPTH(4)) dut (
        .i_clock                       (clk),
        .i_reset                       (rst_n),
        .i_dma_setup_request           (req),
        .i_dma_setup_append_or_replace (app),
        .i_dma_setup_mono_or_stereo    (st),
        .i_dma_setup_address           (s_addr),
        .i_dma_setup_count             (s_cnt),
        .o_dma_request                 (o_dma_request),
        .o_dma_address                 (o_dma_address),
        .o_dma_wdata                   (o_dma_wdata),
        .i_dma_ready                   (i_dma_ready),
        .o_busy                        (o_busy),
        .o_overrun_count               (o_overrun_count),
        .i_input_sample_clock          (s_clk),
        .i_input_sample_left           (s_left),
        .i_input_sample_right          (s_right)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish, got timeout required finish");
        $fatal(1);
    end

    task automatic check_val(input string tag, input logic [31:0] observed,
                             input logic [31:0] expected);
        checks++;
        if (observed !== expected) begin
            errors++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", tag, observed, expected);
        end
    endtask

    // Expected mono word half, straight from the sample rules.
    function automatic logic [15:0] mono_of(input logic [15:0] l, input logic [15:0] r);
        int s;
        s = int'($signed(l)) + int'($signed(r));
        return MONO_MIX ? 16'(s >>> 1) : l;
    endfunction

    // Bus slave: answers each request after ready_delay cycles, logs accepted writes.
    initial begin
        int wait_cnt;
        wait_cnt    = 0;
        i_dma_ready = 1'b0;
        forever begin
            @(negedge clk);
            if (i_dma_ready) begin
                i_dma_ready = 1'b0;
                wait_cnt    = 0;
            end else if (o_dma_request && !ready_hold) begin
                if (wait_cnt >= ready_delay) begin
                    i_dma_ready = 1'b1;
                    got_q.push_back({o_dma_address, o_dma_wdata});
                end else begin
                    wait_cnt++;
                end
            end
        end
    end

    task automatic issue(input bit append, input bit stereo,
                         input logic [31:0] addr, input logic [23:0] cnt);
        @(negedge clk);
        req = 1'b1; app = append; st = stereo; s_addr = addr; s_cnt = cnt;
        @(negedge clk);
        req = 1'b0;
    endtask

    task automatic tick(input logic [15:0] l, input logic [15:0] r, input int gap);
        @(negedge clk);
        s_left = l; s_right = r; s_clk = ~s_clk;
        repeat (gap - 1) @(negedge clk);
    endtask

    task automatic wait_idle(input string tag, input int budget);
        int n;
        n = 0;
        while (o_busy && n < budget) begin
            @(negedge clk);
            n++;
        end
        check_val(tag, {31'd0, o_busy}, 32'd0);
    endtask

    task automatic compare_writes(input string tag);
        check_val({tag, "_nwrites"}, got_q.size(), exp_q.size());
        for (int i = 0; i < exp_q.size(); i++) begin
            if (i < got_q.size()) begin
                check_val({tag, "_addr"}, got_q[i][63:32], exp_q[i][63:32]);
                check_val({tag, "_data"}, got_q[i][31:0],  exp_q[i][31:0]);
            end
        end
        exp_q.delete();
        got_q.delete();
    endtask

    initial begin
        logic [15:0] fl[6];
        logic [15:0] fr[6];
        logic [15:0] rr[3];
        logic [15:0] held;
        logic [31:0] a;

        req = 0; app = 0; st = 0; s_addr = 0; s_cnt = 0;
        s_clk = 0; s_left = 0; s_right = 0;
        rst_n = 1'b0;
        repeat (3) @(negedge clk);
        check_val("rst_req",   {31'd0, o_dma_request}, 32'd0);
        check_val("rst_addr",  o_dma_address, 32'd0);
        check_val("rst_wdata", o_dma_wdata, 32'd0);
        check_val("rst_busy",  {31'd0, o_busy}, 32'd0);
        check_val("rst_ovr",   {24'd0, o_overrun_count}, 32'd0);
        rst_n = 1'b1;
        repeat (2) @(negedge clk);

        // Stereo, ready two cycles late.
        ready_delay = 2;
        issue(1'b0, 1'b1, 32'h1000, 24'd3);
        tick(16'h1111, 16'h2222, 10);
        tick(16'h3333, 16'h4444, 10);
        tick(16'h5555, 16'h6666, 2);
        check_val("st_busy_mid", {31'd0, o_busy}, 32'd1);
        wait_idle("st_idle", 100);
        exp_q.push_back({32'h1000, 32'h11112222});
        exp_q.push_back({32'h1004, 32'h33334444});
        exp_q.push_back({32'h1008, 32'h55556666});
        compare_writes("stereo");

        // Mono, odd count.
        ready_delay = 0;
        for (int i = 0; i < 3; i++) rr[i] = 16'($urandom);
        issue(1'b0, 1'b0, 32'h2000, 24'd3);
        tick(16'h0001, rr[0], 10);
        tick(16'h0002, rr[1], 10);
        tick(16'h0003, rr[2], 10);
        wait_idle("mono_idle", 100);
        exp_q.push_back({32'h2000, mono_of(16'h0002, rr[1]), mono_of(16'h0001, rr[0])});
        exp_q.push_back({32'h2004, 16'h0000, mono_of(16'h0003, rr[2])});
        compare_writes("mono");

`ifdef AUDIO_CAPTURE_MONO_MIX_EN
        issue(1'b0, 1'b0, 32'hA000, 24'd2);
        tick(16'h7FFF, 16'h0001, 10);
        tick(16'h8000, 16'hFFFF, 10);
        wait_idle("mix_idle", 100);
        exp_q.push_back({32'hA000, 32'hBFFF4000});
        compare_writes("mix");
`endif

        // Overrun: one frame in the DMA path, four in the FIFO, the sixth dropped.
        ready_hold = 1'b1;
        for (int i = 0; i < 6; i++) begin fl[i] = 16'($urandom); fr[i] = 16'($urandom); end
        issue(1'b0, 1'b1, 32'h5000, 24'd10);
        for (int i = 0; i < 6; i++) tick(fl[i], fr[i], 8);
        check_val("ovr_count", {24'd0, o_overrun_count}, 32'd1);
        check_val("ovr_req",   {31'd0, o_dma_request}, 32'd1);
        check_val("ovr_addr",  o_dma_address, 32'h5000);
        check_val("ovr_wdata", o_dma_wdata, {fl[0], fr[0]});
        check_val("ovr_nowrite", got_q.size(), 32'd0);
        ready_hold = 1'b0;
        repeat (60) @(negedge clk);
        for (int i = 0; i < 5; i++) exp_q.push_back({32'h5000 + 32'(4 * i), fl[i], fr[i]});
        compare_writes("overrun");
        check_val("ovr_busy_left", {31'd0, o_busy}, 32'd1);

        // Replace mid-write: the in-flight word completes, the FIFO is discarded.
        issue(1'b0, 1'b1, 32'h6000, 24'd10);
        ready_hold = 1'b1;
        for (int i = 0; i < 6; i++) begin fl[i] = 16'($urandom); fr[i] = 16'($urandom); end
        for (int i = 0; i < 6; i++) tick(fl[i], fr[i], 8);
        check_val("rep_ovr_before", {24'd0, o_overrun_count}, 32'd1);
        check_val("rep_req_high", {31'd0, o_dma_request}, 32'd1);
        issue(1'b0, 1'b1, 32'h7000, 24'd1);
        check_val("rep_ovr_clr", {24'd0, o_overrun_count}, 32'd0);
        ready_hold = 1'b0;
        repeat (6) @(negedge clk);
        tick(16'hABCD, 16'h1234, 10);
        wait_idle("rep_idle", 100);
        exp_q.push_back({32'h6000, fl[0], fr[0]});
        exp_q.push_back({32'h7000, 32'hABCD1234});
        compare_writes("replace");

        // Append: B waits until A has fully landed.
        issue(1'b0, 1'b1, 32'h2000, 24'd2);
        tick(16'hA001, 16'hA002, 10);
        issue(1'b1, 1'b1, 32'h3000, 24'd1);
        tick(16'hA003, 16'hA004, 12);
        check_val("app_busy", {31'd0, o_busy}, 32'd1);
        tick(16'hB001, 16'hB002, 10);
        wait_idle("app_idle", 100);
        exp_q.push_back({32'h2000, 32'hA001A002});
        exp_q.push_back({32'h2004, 32'hA003A004});
        exp_q.push_back({32'h3000, 32'hB001B002});
        compare_writes("append");

        // Count zero: loads and completes without bus traffic.
        issue(1'b0, 1'b1, 32'h9000, 24'd0);
        @(negedge clk);
        check_val("zero_busy", {31'd0, o_busy}, 32'd0);
        tick(16'h1234, 16'h5678, 20);
        compare_writes("zero");

        // Randomized commands, issued while idle, with one surplus tick each.
        for (int c = 0; c < 24; c++) begin
            bit          stereo;
            int          cnt;
            logic [15:0] l;
            logic [15:0] r;
            logic [15:0] ms;
            stereo      = 1'($urandom_range(0, 1));
            cnt         = $urandom_range(0, 6);
            ready_delay = $urandom_range(0, 3);
            a           = (c == 0) ? 32'hFFFF_FFF8 : ($urandom & 32'hFFFF_FFFC);
            if (c == 0) cnt = 5;
            issue(1'($urandom_range(0, 1)), stereo, a, 24'(cnt));
            held = '0;
            for (int k = 0; k <= cnt; k++) begin
                l = 16'($urandom);
                r = 16'($urandom);
                if (k < cnt) begin
                    if (stereo) begin
                        exp_q.push_back({a, l, r});
                        a = a + 32'd4;
                    end else begin
                        ms = mono_of(l, r);
                        if (k % 2 == 0 && k == cnt - 1) begin
                            exp_q.push_back({a, 16'h0000, ms});
                            a = a + 32'd4;
                        end else if (k % 2 == 0) begin
                            held = ms;
                        end else begin
                            exp_q.push_back({a, ms, held});
                            a = a + 32'd4;
                        end
                    end
                end
                tick(l, r, $urandom_range(8, 12));
            end
            wait_idle("rnd_idle", 200);
            compare_writes("rnd");
            check_val("rnd_ovr", {24'd0, o_overrun_count}, 32'd0);
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
